// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with two registered read ports,
// one write port, write-to-read bypass and a per-register pending scoreboard.
module reg_file_sb #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] Ard1,
    input  logic [ADDR_W-1:0] Ard2,
    output logic [WIDTH-1:0]  Dout1,
    output logic [WIDTH-1:0]  Dout2,
    input  logic              WE,
    input  logic [ADDR_W-1:0] Awr,
    input  logic [WIDTH-1:0]  Din,
    input  logic              Rsv_en,
    input  logic [ADDR_W-1:0] Rsv_addr,
    output logic              Busy1,
    output logic              Busy2
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    // An address is usable when in range and not the hardwired-zero R0.
    function automatic logic wr_ok(input logic [ADDR_W-1:0] a);
        logic in_rng;
        logic is_r0;
        in_rng = (32'(a) < DEPTH);
        is_r0  = (ZERO_R0 != 0) && (a == '0);
        wr_ok  = in_rng && !is_r0;
    endfunction

    // Read value seen by a port, with the same-cycle write bypassed in.
    function automatic logic [WIDTH-1:0] rd(input logic [ADDR_W-1:0] a);
        rd = '0;
        if (wr_ok(a)) begin
            if (WE && (Awr == a))
                rd = Din;
            else
                rd = regs[a];
        end
    endfunction

    // Combinational read data for both ports.
    always_comb begin
        rd1 = rd(Ard1);
        rd2 = rd(Ard2);
    end

    // Storage update: at most one write per clock.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (WE && wr_ok(Awr)) begin
            regs[Awr] <= Din;
        end
    end

    // Registered read outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Dout1 <= '0;
            Dout2 <= '0;
        end else begin
            Dout1 <= rd1;
            Dout2 <= rd2;
        end
    end

    // Scoreboard next state: a new reservation beats a completing write.
    always_comb begin
        pend_nxt = pend;
        if (WE && wr_ok(Awr))
            pend_nxt[Awr] = 1'b0;
        if (Rsv_en && wr_ok(Rsv_addr))
            pend_nxt[Rsv_addr] = 1'b1;
    end

    // Scoreboard register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            pend <= '0;
        else
            pend <= pend_nxt;
    end

    // Stall flags; a write completing this cycle releases the stall.
    always_comb begin
        Busy1 = 1'b0;
        Busy2 = 1'b0;
        if (wr_ok(Ard1))
            Busy1 = pend[Ard1] && !(WE && (Awr == Ard1));
        if (wr_ok(Ard2))
            Busy2 = pend[Ard2] && !(WE && (Awr == Ard2));
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: three configurations driven by shared stimulus
// (default, ZERO_R0=0, DEPTH=20), each checked against an array model.
module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ard1;
    logic [4:0]  ard2;
    logic        we;
    logic [4:0]  awr;
    logic [31:0] din;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic [31:0] d1 [3];
    logic [31:0] d2 [3];
    logic        b1 [3];
    logic        b2 [3];

    int errors = 0;
    int checks = 0;

    int dep [3] = '{32, 32, 20};
    bit zr  [3] = '{1'b1, 1'b0, 1'b1};

    logic [31:0] mreg  [3][32];
    bit          mpend [3][32];
    logic [31:0] e1 [3];
    logic [31:0] e2 [3];

    reg_file_sb #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_R0(1)) u0 (
        .Clk(clk), .Rst_n(rst_n), .Ard1(ard1), .Ard2(ard2),
        .Dout1(d1[0]), .Dout2(d2[0]), .WE(we), .Awr(awr), .Din(din),
        .Rsv_en(rsv_en), .Rsv_addr(rsv_addr), .Busy1(b1[0]), .Busy2(b2[0]));

    reg_file_sb #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_R0(0)) u1 (
        .Clk(clk), .Rst_n(rst_n), .Ard1(ard1), .Ard2(ard2),
        .Dout1(d1[1]), .Dout2(d2[1]), .WE(we), .Awr(awr), .Din(din),
        .Rsv_en(rsv_en), .Rsv_addr(rsv_addr), .Busy1(b1[1]), .Busy2(b2[1]));

    reg_file_sb #(.WIDTH(32), .DEPTH(20), .ADDR_W(5), .ZERO_R0(1)) u2 (
        .Clk(clk), .Rst_n(rst_n), .Ard1(ard1), .Ard2(ard2),
        .Dout1(d1[2]), .Dout2(d2[2]), .WE(we), .Awr(awr), .Din(din),
        .Rsv_en(rsv_en), .Rsv_addr(rsv_addr), .Busy1(b1[2]), .Busy2(b2[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit vld(int k, int a);
        return (a < dep[k]) && !(zr[k] && a == 0);
    endfunction

    function automatic logic [31:0] mrd(int k, int a);
        if (!vld(k, a)) return 32'h0;
        if (we && int'(awr) == a) return din;
        return mreg[k][a];
    endfunction

    function automatic bit mbusy(int k, int a);
        return vld(k, a) && mpend[k][a] && !(we && int'(awr) == a);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 32; a++) begin
                mreg[k][a]  = 32'h0;
                mpend[k][a] = 1'b0;
            end
    endtask

    task automatic drive(input bit w, input int wa, input logic [31:0] wd,
                         input int a1, input int a2,
                         input bit r, input int ra);
        we       = w;
        awr      = wa[4:0];
        din      = wd;
        ard1     = a1[4:0];
        ard2     = a2[4:0];
        rsv_en   = r;
        rsv_addr = ra[4:0];
        #1;
    endtask

    // Advance one clock: predict read data, then apply the write and
    // scoreboard rules to the model.
    task automatic step();
        for (int k = 0; k < 3; k++) begin
            e1[k] = mrd(k, int'(ard1));
            e2[k] = mrd(k, int'(ard2));
        end
        for (int k = 0; k < 3; k++) begin
            if (we && vld(k, int'(awr))) begin
                mreg[k][awr]  = din;
                mpend[k][awr] = 1'b0;
            end
            if (rsv_en && vld(k, int'(rsv_addr)))
                mpend[k][rsv_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (d1[k] !== 32'h0 || d2[k] !== 32'h0 ||
                b1[k] !== 1'b0 || b2[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_init inst%0d d1=%h d2=%h b1=%b b2=%b exp all 0",
                         k, d1[k], d2[k], b1[k], b2[k]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 5, 32'hDEADBEEF, 5, 5, 1, 5);
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (d1[k] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL reset_prewrite inst%0d got=%h exp=%h",
                         k, d1[k], 32'hDEADBEEF);
            end
        end
        drive(1, 5, 32'h11111111, 5, 5, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (d1[k] !== 32'h0 || d2[k] !== 32'h0 ||
                b1[k] !== 1'b0 || b2[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_async inst%0d d1=%h d2=%h b1=%b b2=%b exp all 0",
                         k, d1[k], d2[k], b1[k], b2[k]);
            end
        end
        drive(0, 0, 32'h0, 5, 5, 0, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (b1[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy inst%0d got=%b exp=0", k, b1[k]);
            end
        end
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (d1[k] !== 32'h0 || d1[k] !== e1[k]) begin
                errors++;
                $display("FAIL reset_r5 inst%0d got=%h exp=0", k, d1[k]);
            end
        end
    endtask

    task automatic test_basic_rw();
        drive(1, 3, 32'h12345678, 0, 0, 0, 0);
        step();
        drive(0, 0, 32'h0, 3, 3, 0, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (d1[k] !== 32'h12345678 || d2[k] !== 32'h12345678) begin
                errors++;
                $display("FAIL basic_rw inst%0d d1=%h d2=%h exp=%h",
                         k, d1[k], d2[k], 32'h12345678);
            end
        end
    endtask

    task automatic test_bypass();
        drive(1, 7, 32'h01010101, 0, 0, 0, 0);
        step();
        drive(1, 7, 32'hA5A5A5A5, 7, 3, 0, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (d1[k] !== 32'hA5A5A5A5 || d2[k] !== e2[k]) begin
                errors++;
                $display("FAIL bypass inst%0d d1=%h exp=%h d2=%h exp=%h",
                         k, d1[k], 32'hA5A5A5A5, d2[k], e2[k]);
            end
        end
    endtask

    task automatic test_r0();
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 1, 0);
        step();
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (b1[k] !== mbusy(k, 0)) begin
                errors++;
                $display("FAIL r0_busy inst%0d got=%b exp=%b",
                         k, b1[k], mbusy(k, 0));
            end
        end
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (d1[k] !== e1[k]) begin
                errors++;
                $display("FAIL r0_read inst%0d got=%h exp=%h", k, d1[k], e1[k]);
            end
        end
        checks++;
        if (d1[0] !== 32'h0 || d1[1] !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL r0_cfg zr1=%h exp=0 zr0=%h exp=ffffffff", d1[0], d1[1]);
        end
    endtask

    task automatic test_scoreboard();
        drive(0, 0, 32'h0, 9, 9, 1, 9);
        step();
        drive(0, 0, 32'h0, 9, 9, 0, 0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (b1[k] !== 1'b1 || b2[k] !== 1'b1) begin
                errors++;
                $display("FAIL sb_reserve inst%0d b1=%b b2=%b exp=1", k, b1[k], b2[k]);
            end
        end
        drive(1, 9, 32'h55, 9, 9, 0, 0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (b1[k] !== 1'b0) begin
                errors++;
                $display("FAIL sb_release inst%0d got=%b exp=0", k, b1[k]);
            end
        end
        step();
        drive(1, 9, 32'h66, 9, 9, 1, 9);
        step();
        drive(0, 0, 32'h0, 9, 9, 0, 0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (b1[k] !== 1'b1 || b1[k] !== mbusy(k, 9)) begin
                errors++;
                $display("FAIL sb_setwins inst%0d got=%b exp=1", k, b1[k]);
            end
        end
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (d1[k] !== 32'h66) begin
                errors++;
                $display("FAIL sb_data inst%0d got=%h exp=%h", k, d1[k], 32'h66);
            end
        end
        drive(1, 9, 32'h77, 9, 9, 0, 0);
        step();
    endtask

    task automatic test_out_of_range();
        drive(1, 25, 32'h77, 25, 25, 1, 25);
        checks++;
        if (b1[2] !== 1'b0) begin
            errors++;
            $display("FAIL oor_busy_pre got=%b exp=0", b1[2]);
        end
        step();
        drive(0, 0, 32'h0, 25, 25, 0, 0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (b1[k] !== mbusy(k, 25)) begin
                errors++;
                $display("FAIL oor_busy inst%0d got=%b exp=%b", k, b1[k], mbusy(k, 25));
            end
        end
        step();
        checks++;
        if (d1[2] !== 32'h0) begin
            errors++;
            $display("FAIL oor_read got=%h exp=0", d1[2]);
        end
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 32'h0, a, 31 - a, 0, 0);
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (d1[k] !== e1[k] || d2[k] !== e2[k]) begin
                    errors++;
                    $display("FAIL oor_sweep inst%0d a=%0d d1=%h exp=%h d2=%h exp=%h",
                             k, a, d1[k], e1[k], d2[k], e2[k]);
                end
            end
        end
    endtask

    function automatic int rnd_addr();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 31));
        return int'($urandom_range(0, 3)) + 8;
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1) == 1, rnd_addr(), $urandom(),
                  rnd_addr(), rnd_addr(),
                  $urandom_range(0, 2) == 0, rnd_addr());
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (b1[k] !== mbusy(k, int'(ard1)) ||
                    b2[k] !== mbusy(k, int'(ard2))) begin
                    errors++;
                    $display("FAIL rnd_busy inst%0d n=%0d b1=%b exp=%b b2=%b exp=%b",
                             k, n, b1[k], mbusy(k, int'(ard1)),
                             b2[k], mbusy(k, int'(ard2)));
                end
            end
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (d1[k] !== e1[k] || d2[k] !== e2[k]) begin
                    errors++;
                    $display("FAIL rnd_read inst%0d n=%0d d1=%h exp=%h d2=%h exp=%h",
                             k, n, d1[k], e1[k], d2[k], e2[k]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        drive(0, 0, 32'h0, 0, 0, 0, 0);
        #2;
        test_reset();
        test_basic_rw();
        test_bypass();
        test_r0();
        test_scoreboard();
        test_out_of_range();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file; the multi-entry successor to the single 32-bit write-enabled register.
- DEPTH registers of WIDTH bits, two registered read ports, one write port, write-to-read bypass, optional hardwired-zero R0.
- Adds a per-register pending scoreboard so the decode stage can stall on registers awaiting multi-cycle results (loads, multiply).
- Sits between decode (read addresses, reserve) and writeback (write port).

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers. Range 2 to 2^ADDR_W.
- ADDR_W, 5, address width of all address ports.
- ZERO_R0, 1, 1 means register 0 reads as 0, ignores writes and is never pending.

Ports:
- Clk  input  1  clock; all state updates on posedge only.
- Rst_n  input  1  asynchronous active-low reset.
- Ard1  input  ADDR_W  read port 1 address.
- Ard2  input  ADDR_W  read port 2 address.
- Dout1  output  WIDTH  read port 1 data, registered.
- Dout2  output  WIDTH  read port 2 data, registered.
- WE  input  1  write enable.
- Awr  input  ADDR_W  write address.
- Din  input  WIDTH  write data.
- Rsv_en  input  1  reserve request: mark Rsv_addr pending.
- Rsv_addr  input  ADDR_W  register to reserve.
- Busy1  output  1  pending status of Ard1, combinational.
- Busy2  output  1  pending status of Ard2, combinational.

Behaviour:
- Reset: Rst_n low immediately clears all registers, Dout1/Dout2 and all pending bits to 0, regardless of Clk. This includes a reset asserted mid-write. The first posedge after release operates normally.
- Write valid: an address is valid when addr < DEPTH and not (ZERO_R0 and addr == 0).
- Write: on posedge, if WE and Awr is valid, reg[Awr] <= Din. Otherwise storage holds. Exactly one update per clock; negedge does nothing.
- Read latency: 1 cycle. On every posedge, Dout1 <= rd(Ard1); same rule for Dout2 with Ard2. Read ports are independent; Ard1 == Ard2 is legal.
- rd(a):
  - 0 if a >= DEPTH.
  - 0 if ZERO_R0 and a == 0.
  - Din if WE and Awr == a and a is write-valid (bypass).
  - reg[a] otherwise.
- Scoreboard: pending[DEPTH] updated on posedge.
  - Set when Rsv_en and Rsv_addr is write-valid.
  - Cleared when WE and Awr is write-valid.
  - Same address set and cleared in the same cycle: set wins (new reservation supersedes the completing write).
  - Reserve of an already-pending register: stays pending.
  - Write to a non-pending register: bit stays 0.
- Busy1 = pending[Ard1] and not (WE and Awr == Ard1).
  - A completing write in the current cycle releases the stall, consistent with the bypass.
  - Busy is 0 for invalid or R0 (when ZERO_R0) addresses.
  - Busy2 follows the same rule.
- Invalid addresses (>= DEPTH): writes and reserves are ignored. No error output.

Test Plan:
- Reset: write 0xDEADBEEF to R5, then pulse Rst_n low between edges -> Dout1/Dout2 = 0 immediately; R5 reads 0 after release; Busy1/Busy2 = 0.
- Basic write/read: write 0x12345678 to R3, next cycle Ard1 = 3 -> Dout1 = 0x12345678 one posedge later. Ard2 = 3 at the same time -> Dout2 identical.
- Bypass: WE = 1, Awr = 7, Din = 0xA5A5A5A5, Ard1 = 7 in the same cycle -> Dout1 = 0xA5A5A5A5 after that posedge, not the old R7 value.
- R0 with ZERO_R0 = 1: write 0xFFFFFFFF to R0, Rsv_en to R0 -> Dout1 = 0 and Busy1 = 0 for Ard1 = 0.
- R0 with ZERO_R0 = 0: same stimulus -> Dout1 = 0xFFFFFFFF.
- Scoreboard sequence on R9, Ard1 = 9:
  - Reserve R9 -> Busy1 = 1 next cycle.
  - Write R9 = 0x55 -> Busy1 = 0 combinationally in the write cycle.
  - Simultaneous reserve and write of R9 -> Busy1 = 1 after the edge, and R9 = written value.
- Out of range, DEPTH = 20: write 0x77 to address 25, reserve 25 -> Dout1 = 0 and Busy1 = 0 for Ard1 = 25; R0 through R19 are unchanged.
